// File: rtl/mac_poly_n_if.sv
// mac_poly_n_if: stream bus between the coefficient sequencer and the
// Horner polynomial evaluator.
//
// Signals
//   t_in     [BT-1:0]        evaluation point, unsigned Q0.BT
//   c_in     [(N+1)*BC-1:0]  packed coefficients, ck = c_in[k*BC +: BC]
//   in_valid                 qualifies t_in/c_in
//   y_out    [BY-1:0]        result, signed Q1.(BY-1)
//   y_valid                  y_out holds a result
//   y_sat                    y_out was clamped, aligned with y_out
//
// Handshake: valid-only with no ready. The consumer cannot push back.
// A sample is taken on every clk edge where the evaluator's en is high and
// in_valid is high. A result is delivered on every clk edge where en is high
// and y_valid is high. While en is low, y_valid is only a held copy and
// carries no new result. y_out and y_sat mean nothing while y_valid is low.
//
// Modports
//   master  sequencer side: drives the inputs and reads the results
//   slave   evaluator side
interface mac_poly_n_if #(
  parameter int N  = 3,
  parameter int BC = 16,
  parameter int BT = 16,
  parameter int BY = 16
);
  logic [BT-1:0]       t_in;
  logic [(N+1)*BC-1:0] c_in;
  logic                in_valid;
  logic [BY-1:0]       y_out;
  logic                y_valid;
  logic                y_sat;

  modport master (
    output t_in, c_in, in_valid,
    input  y_out, y_valid, y_sat
  );

  modport slave (
    input  t_in, c_in, in_valid,
    output y_out, y_valid, y_sat
  );
endinterface

// File: rtl/mac_poly_n.sv
// mac_poly_n: pipelined Horner-form polynomial evaluator.
//   y = c0 + (c1 + (... + cN*t)...)*t
//
// Each of the N MAC stages is three registers deep:
//   1) the multiplicand m_j is registered
//   2) the full signed product m_j * t is registered
//   3) the product is floored by 2^BT, the coefficient is added, and the
//      sum is saturated to BADD bits and registered
// One more register forms the output, which narrows the result to BY bits
// with saturation. Latency is 3N+1 enabled cycles. One sample is accepted
// per enabled cycle.
//
// Ports
//   clk    clock
//   rstn   asynchronous active-low reset; clears every register
//   en     pipeline clock-enable; every register holds while en is low
//   bus    mac_poly_n_if.slave (t_in, c_in, in_valid / y_out, y_valid, y_sat)
module mac_poly_n #(
  parameter int N  = 3,
  parameter int BC = 16,
  parameter int BT = 16,
  parameter int BY = 16
) (
  input logic         clk,
  input logic         rstn,
  input logic         en,
  mac_poly_n_if.slave bus
);

  localparam int BGUARD = $clog2(N + 1);
  localparam int BADD   = BC + BGUARD;
  localparam int BP     = BADD + BT + 1;
  localparam int D      = 3 * N;
  localparam int CW     = (N + 1) * BC;

  localparam logic signed [BADD-1:0] ADD_MAX = {1'b0, {(BADD-1){1'b1}}};
  localparam logic signed [BADD-1:0] ADD_MIN = {1'b1, {(BADD-1){1'b0}}};
  localparam logic [BY-1:0]          Y_MAX   = {1'b0, {(BY-1){1'b1}}};
  localparam logic [BY-1:0]          Y_MIN   = {1'b1, {(BY-1){1'b0}}};

  // Delay lines that carry t, the coefficient word and valid alongside the
  // data path. Entry k holds the value captured k enabled edges ago.
  // Stage j reads t at entry 3j+1 (product cycle) and reads its
  // coefficient at entry 3j+2 (add cycle). The chains stop at the last
  // entry that any stage reads.
  logic [BT-1:0] t_d [1:D-2];
  logic [CW-1:0] c_d [1:D-1];
  logic          v_d [1:D];

  logic signed [BADD-1:0] m_r   [0:N-1];
  logic signed [BADD-1:0] m_nx  [0:N-1];
  logic signed [BP-1:0]   p_r   [0:N-1];
  logic signed [BP-1:0]   p_nx  [0:N-1];
  logic signed [BC-1:0]   cf_w  [0:N-1];
  logic signed [BADD:0]   sum_w [0:N-1];
  logic signed [BADD-1:0] y_r   [0:N-1];
  logic signed [BADD-1:0] y_nx  [0:N-1];

  logic [BADD-1:0] top;
  logic            ovf;
  logic [BY-1:0]   y_out_nx;

  always_comb begin
    // Stage 0 starts from cN. Every later stage starts from the previous stage's result.
    m_nx[0] = BADD'($signed(bus.c_in[N*BC +: BC]));
    for (int j = 1; j < N; j++) begin
      m_nx[j] = y_r[j-1];
    end

    for (int j = 0; j < N; j++) begin
      // t is unsigned, so it gets a zero top bit before the signed multiply.
      p_nx[j] = BP'(m_r[j]) * $signed(BP'({1'b0, t_d[3*j+1]}));

      // The top BADD+1 bits of the product are floor(m*t / 2^BT).
      cf_w[j]  = $signed(c_d[3*j+2][(N-1-j)*BC +: BC]);
      sum_w[j] = $signed(p_r[j][BT +: BADD+1]) + (BADD+1)'(cf_w[j]);

      if (sum_w[j][BADD] != sum_w[j][BADD-1]) begin
        y_nx[j] = sum_w[j][BADD] ? ADD_MIN : ADD_MAX;
      end else begin
        y_nx[j] = sum_w[j][BADD-1:0];
      end
    end
  end

  // The result fits in Q1.(BC-1) only when every guard bit matches the sign bit.
  always_comb begin
    top      = y_r[N-1];
    ovf      = !((&top[BADD-1:BC-1]) || !(|top[BADD-1:BC-1]));
    y_out_nx = top[BC-1 -: BY];
    if (ovf) begin
      y_out_nx = top[BADD-1] ? Y_MIN : Y_MAX;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= D - 2; k++) t_d[k] <= '0;
      for (int k = 1; k <= D - 1; k++) c_d[k] <= '0;
      for (int k = 1; k <= D; k++)     v_d[k] <= 1'b0;
      for (int j = 0; j < N; j++) begin
        m_r[j] <= '0;
        p_r[j] <= '0;
        y_r[j] <= '0;
      end
      bus.y_out   <= '0;
      bus.y_valid <= 1'b0;
      bus.y_sat   <= 1'b0;
    end else if (en) begin
      t_d[1] <= bus.t_in;
      for (int k = 2; k <= D - 2; k++) t_d[k] <= t_d[k-1];
      c_d[1] <= bus.c_in;
      for (int k = 2; k <= D - 1; k++) c_d[k] <= c_d[k-1];
      v_d[1] <= bus.in_valid;
      for (int k = 2; k <= D; k++)     v_d[k] <= v_d[k-1];
      for (int j = 0; j < N; j++) begin
        m_r[j] <= m_nx[j];
        p_r[j] <= p_nx[j];
        y_r[j] <= y_nx[j];
      end
      bus.y_out   <= y_out_nx;
      bus.y_valid <= v_d[D];
      bus.y_sat   <= ovf;
    end
  end

endmodule

// File: tb/tb_mac_poly_n.sv
// tb_mac_poly_n: directed bench for mac_poly_n with N=3 and BC=BT=BY=16.
// Results are sampled 1 time unit after each rising edge.
module tb_mac_poly_n;
  localparam int N  = 3;
  localparam int BC = 16;
  localparam int BT = 16;
  localparam int BY = 16;
  localparam int L  = 3 * N + 1;

  logic clk = 1'b0;
  logic rstn;
  logic en;

  mac_poly_n_if #(.N(N), .BC(BC), .BT(BT), .BY(BY)) bus ();

  mac_poly_n #(.N(N), .BC(BC), .BT(BT), .BY(BY)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .bus  (bus)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  logic [BY-1:0] exp_q[$];
  int            due_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.t_in     = '0;
    bus.c_in     = '0;
  endtask

  task automatic drive(input logic [15:0] t, input logic [63:0] c);
    bus.in_valid = 1'b1;
    bus.t_in     = t;
    bus.c_in     = c;
  endtask

  function automatic logic [63:0] coefs(input logic [15:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // One sample. It is captured on edge 1 and its result must show on edge L only.
  task automatic run_one(input string tag, input logic [15:0] t, input logic [63:0] c,
                         input logic [15:0] ey, input logic es);
    drive(t, c);
    tick();
    idle();
    for (int k = 2; k <= L + 1; k++) begin
      tick();
      if (k == L - 1) check({tag, " early_valid"}, bus.y_valid, 1'b0);
      if (k == L) begin
        check({tag, " valid"}, bus.y_valid, 1'b1);
        check({tag, " y_out"}, bus.y_out, ey);
        check({tag, " y_sat"}, bus.y_sat, es);
      end
      if (k == L + 1) check({tag, " late_valid"}, bus.y_valid, 1'b0);
    end
  endtask

  initial begin
    int ecnt;
    int sent;
    int pulses;
    int pulse_edge;
    logic en_was;

    // reset state
    rstn = 1'b0;
    en   = 1'b0;
    idle();
    #12;
    check("reset y_valid", bus.y_valid, 1'b0);
    check("reset y_out", bus.y_out, 16'h0000);
    check("reset y_sat", bus.y_sat, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    en   = 1'b1;
    tick();

    // constant, linear and cubic polynomials
    run_one("const", 16'h1234, coefs(16'h2000, 16'h0000, 16'h0000, 16'h0000), 16'h2000, 1'b0);
    run_one("linear", 16'h8000, coefs(16'h0000, 16'h4000, 16'h0000, 16'h0000), 16'h2000, 1'b0);
    run_one("cubic", 16'h8000, coefs(16'h0000, 16'h0000, 16'h0000, 16'h4000), 16'h0800, 1'b0);

    // Back-to-back cubic samples.
    // t=0xFFFF: 0x4000*0xFFFF>>16=0x3FFF, 0x3FFF*0xFFFF>>16=0x3FFE, 0x3FFE*0xFFFF>>16=0x3FFD
    drive(16'h8000, coefs(16'h0000, 16'h0000, 16'h0000, 16'h4000));
    tick();
    drive(16'hFFFF, coefs(16'h0000, 16'h0000, 16'h0000, 16'h4000));
    tick();
    idle();
    for (int k = 3; k <= L + 2; k++) begin
      tick();
      if (k == L) check("pair first y_out", bus.y_out, 16'h0800);
      if (k == L + 1) begin
        check("pair second valid", bus.y_valid, 1'b1);
        check("pair second y_out", bus.y_out, 16'h3FFD);
      end
      if (k == L + 2) check("pair end valid", bus.y_valid, 1'b0);
    end

    // Saturation: 0x7FFF + 0x7FFE overflows upward; -0x8000 + -0x8000 overflows downward.
    run_one("sat_pos", 16'hFFFF, coefs(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000), 16'h7FFF, 1'b1);
    run_one("sat_neg", 16'hFFFF, coefs(16'h8000, 16'h8000, 16'h0000, 16'h0000), 16'h8000, 1'b1);

    // Stream of 20 samples with a 5-cycle en=0 stall. Sample k uses c0=k*0x100,
    // c1=0x4000 and t=k*0x800, so y = k*0x100 + k*0x200 = k*0x300.
    // Each result is due exactly L enabled edges after its sample.
    ecnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      en = !(cyc >= 8 && cyc < 13);
      if (en && sent < 20) begin
        drive(16'(sent << 11), coefs(16'(sent << 8), 16'h4000, 16'h0000, 16'h0000));
        exp_q.push_back(16'(sent * 16'h0300));
        due_q.push_back(ecnt + L);
        sent++;
      end else begin
        idle();
      end
      en_was = en;
      tick();
      if (en_was) begin
        ecnt++;
        if (bus.y_valid) begin
          if (exp_q.size() == 0) begin
            check("stream extra result", 1'b1, 1'b0);
          end else begin
            check("stream y_out", bus.y_out, exp_q.pop_front());
            check("stream latency", ecnt, due_q.pop_front());
            check("stream y_sat", bus.y_sat, 1'b0);
          end
        end
      end
    end
    en = 1'b1;
    check("stream drained", exp_q.size(), 0);

    // Reset in the middle of a stream.
    for (int k = 0; k < 12; k++) begin
      drive(16'($urandom_range(0, 16'hFFFF)), coefs(16'h1000, 16'h0000, 16'h0000, 16'h0000));
      tick();
    end
    idle();
    check("pre_reset valid", bus.y_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_reset y_valid", bus.y_valid, 1'b0);
    check("mid_reset y_out", bus.y_out, 16'h0000);
    check("mid_reset y_sat", bus.y_sat, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    drive(16'h1234, coefs(16'h2000, 16'h0000, 16'h0000, 16'h0000));
    tick();
    idle();
    pulses     = 0;
    pulse_edge = 0;
    for (int k = 2; k <= 2 * L; k++) begin
      tick();
      if (bus.y_valid) begin
        pulses++;
        pulse_edge = k;
      end
    end
    check("post_reset pulses", pulses, 1);
    check("post_reset pulse edge", pulse_edge, L);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
